// File: rtl/float_div_pkg.sv
// Shared types and helpers for the pipelined floating-point divider.
// Operand classes, the flag record and the default-format constants live here.
package float_div_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;
   localparam int BIAS      = (1 << (EXP_W_DEF - 1)) - 1;
   localparam logic [EXP_W_DEF+MAN_W_DEF:0] CANON_NAN =
      {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   typedef struct packed {
      logic invalid;
      logic div_by_zero;
      logic overflow;
      logic underflow;
      logic inexact;
   } fdiv_flags_t;

   // Denormals are flushed: a zero exponent classifies as zero whatever the fraction.
   function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                          input logic frac_nz);
      if (exp_zero)
         return FP_ZERO;
      if (exp_ones)
         return frac_nz ? FP_NAN : FP_INF;
      return FP_NORM;
   endfunction

endpackage

// File: rtl/fdiv_mant_pipe.sv
// Restoring mantissa divider, one quotient bit per stage; latency MAN_W+4 cycles.
// No backpressure: a new operand pair enters every cycle, side-band rides alongside unchanged.
module fdiv_mant_pipe #(
   parameter int MAN_W  = 23,
   parameter int SIDE_W = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              in_valid,
   input  logic [MAN_W:0]    ma,
   input  logic [MAN_W:0]    mb,
   input  logic [SIDE_W-1:0] side_in,
   output logic              out_valid,
   output logic [MAN_W+3:0]  q,
   output logic [MAN_W:0]    rem,
   output logic [SIDE_W-1:0] side_out
);

   localparam int NST = MAN_W + 4;
   localparam int QW  = MAN_W + 4;
   localparam int RW  = MAN_W + 1;

   logic [NST-1:0][RW-1:0]     rem_q, rem_d;
   logic [NST-1:0][QW-1:0]     q_q, q_d, q_in;
   logic [NST-1:0][RW:0]       t_in;
   logic [NST-1:0][RW-1:0]     mb_in;
   logic [NST-2:0][RW-1:0]     mb_q;
   logic [NST-1:0][SIDE_W-1:0] side_q;
   logic [NST-1:0]             vld_q;

   // ma < 2*mb, so every partial remainder stays below mb and fits in RW bits.
   always_comb begin
      t_in     = '0;
      mb_in    = '0;
      q_in     = '0;
      rem_d    = '0;
      q_d      = '0;
      t_in[0]  = {1'b0, ma};
      mb_in[0] = mb;
      for (int k = 1; k < NST; k++) begin
         t_in[k]  = {rem_q[k-1], 1'b0};
         mb_in[k] = mb_q[k-1];
         q_in[k]  = q_q[k-1];
      end
      for (int k = 0; k < NST; k++) begin
         if (t_in[k] >= {1'b0, mb_in[k]}) begin
            rem_d[k] = RW'(t_in[k] - {1'b0, mb_in[k]});
            q_d[k]   = q_in[k] | (QW'(1) << (QW - 1 - k));
         end else begin
            rem_d[k] = t_in[k][RW-1:0];
            q_d[k]   = q_in[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      q_q    <= q_d;
      mb_q   <= mb_in[NST-2:0];
      side_q <= {side_q[NST-2:0], side_in};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         vld_q <= '0;
      else
         vld_q <= {vld_q[NST-2:0], in_valid};
   end

   assign out_valid = vld_q[NST-1];
   assign q         = q_q[NST-1];
   assign rem       = rem_q[NST-1];
   assign side_out  = side_q[NST-1];

endmodule

// File: rtl/float_div_pipe.sv
// Streaming floating-point divider with RTZ/RNE rounding, specials and flags; latency MAN_W+7.
// No backpressure: accepts one operation per cycle, results in order with the tag returned.
module float_div_pipe
   import float_div_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [EXP_W+MAN_W:0]   din1,
   input  logic [EXP_W+MAN_W:0]   din2,
   input  logic                   rnd_rne,
   input  logic [TAG_W-1:0]       din_tag,
   input  logic                   din_valid,
   output logic [EXP_W+MAN_W:0]   dout,
   output logic [TAG_W-1:0]       dout_tag,
   output logic [4:0]             dout_flags,
   output logic                   dout_valid
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 2;
   localparam int QW = MAN_W + 4;

   // Package constants describe the default format; other widths derive their own.
   localparam int BIAS_L = (EXP_W == EXP_W_DEF) ? BIAS : (1 << (EXP_W - 1)) - 1;
   localparam logic [W-1:0] NAN_PAT = (EXP_W == EXP_W_DEF && MAN_W == MAN_W_DEF) ?
      W'(CANON_NAN) : {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

   typedef struct packed {
      logic             rnd;
      logic [TAG_W-1:0] tag;
      logic             sign;
      logic [EW-1:0]    e;
      fp_class_e        ca;
      fp_class_e        cb;
   } side_t;

   localparam int SIDE_W = $bits(side_t);

   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;

   assign ea = din1[W-2 -: EXP_W];
   assign eb = din2[W-2 -: EXP_W];
   assign fa = din1[MAN_W-1:0];
   assign fb = din2[MAN_W-1:0];

   side_t          s1_side;
   logic [MAN_W:0] s1_ma, s1_mb;
   logic           s1_valid;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         s1_valid <= 1'b0;
      else
         s1_valid <= din_valid;
   end

   always_ff @(posedge clk) begin
      s1_ma        <= {1'b1, fa};
      s1_mb        <= {1'b1, fb};
      s1_side.rnd  <= rnd_rne;
      s1_side.tag  <= din_tag;
      s1_side.sign <= din1[W-1] ^ din2[W-1];
      s1_side.e    <= {2'b00, ea} - {2'b00, eb} + EW'(BIAS_L);
      s1_side.ca   <= classify(ea == '0, &ea, |fa);
      s1_side.cb   <= classify(eb == '0, &eb, |fb);
   end

   logic [QW-1:0]  q_m;
   logic [MAN_W:0] rem_m;
   side_t          side_m;
   logic           vld_m;

   fdiv_mant_pipe #(
      .MAN_W  (MAN_W),
      .SIDE_W (SIDE_W)
   ) u_mant (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (s1_valid),
      .ma        (s1_ma),
      .mb        (s1_mb),
      .side_in   (s1_side),
      .out_valid (vld_m),
      .q         (q_m),
      .rem       (rem_m),
      .side_out  (side_m)
   );

   logic           msb;
   side_t          side_n;
   side_t          n_side;
   logic [MAN_W-1:0] n_frac;
   logic           n_g, n_s, n_valid;

   assign msb = q_m[QW-1];

   // A quotient below 1.0 leaves the top bit clear and costs one exponent step.
   always_comb begin
      side_n   = side_m;
      side_n.e = side_m.e - EW'(!msb);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         n_valid <= 1'b0;
      else
         n_valid <= vld_m;
   end

   always_ff @(posedge clk) begin
      n_side <= side_n;
      n_frac <= msb ? q_m[MAN_W+2:3] : q_m[MAN_W+1:2];
      n_g    <= msb ? q_m[2] : q_m[1];
      n_s    <= (msb ? |q_m[1:0] : q_m[0]) | (|rem_m);
   end

   logic             rup, carry, ovf, unf;
   logic [MAN_W-1:0] frac_r;
   logic [EW-1:0]    e_r;
   logic [W-1:0]     res;
   fdiv_flags_t      fl;

   assign rup            = n_side.rnd & n_g & (n_s | n_frac[0]);
   assign {carry, frac_r} = {1'b0, n_frac} + (MAN_W+1)'(rup);
   assign e_r            = n_side.e + EW'(carry);
   assign ovf            = !e_r[EW-1] && (e_r >= EMAX);
   assign unf            = e_r[EW-1] || (e_r == '0);

   always_comb begin
      res        = {n_side.sign, e_r[EXP_W-1:0], frac_r};
      fl         = '0;
      fl.inexact = n_g | n_s;
      if (n_side.ca == FP_NAN || n_side.cb == FP_NAN ||
          (n_side.ca == FP_ZERO && n_side.cb == FP_ZERO) ||
          (n_side.ca == FP_INF && n_side.cb == FP_INF)) begin
         res        = NAN_PAT;
         fl         = '0;
         fl.invalid = 1'b1;
      end else if (n_side.cb == FP_ZERO) begin
         res            = {n_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         fl             = '0;
         fl.div_by_zero = (n_side.ca == FP_NORM);
      end else if (n_side.ca == FP_INF) begin
         res = {n_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         fl  = '0;
      end else if (n_side.cb == FP_INF || n_side.ca == FP_ZERO) begin
         res = {n_side.sign, {(W-1){1'b0}}};
         fl  = '0;
      end else if (ovf) begin
         res = n_side.rnd ? {n_side.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {n_side.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         fl.overflow = 1'b1;
         fl.inexact  = 1'b1;
      end else if (unf) begin
         res          = {n_side.sign, {(W-1){1'b0}}};
         fl.underflow = 1'b1;
         fl.inexact   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dout       <= '0;
         dout_tag   <= '0;
         dout_flags <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= n_valid;
         if (n_valid) begin
            dout       <= res;
            dout_tag   <= n_side.tag;
            dout_flags <= fl;
         end
      end
   end

endmodule

// File: tb/tb_float_div_pipe.sv
// Bench for float_div_pipe: directed vector table, random stream and mid-flight reset,
// all results checked through an in-order expected-result queue.
module tb_float_div_pipe;

   localparam int LAT = 30;

   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] din1, din2, dout;
   logic        rnd_rne, din_valid, dout_valid;
   logic [3:0]  din_tag, dout_tag;
   logic [4:0]  dout_flags;

   float_div_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .din1       (din1),
      .din2       (din2),
      .rnd_rne    (rnd_rne),
      .din_tag    (din_tag),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_tag   (dout_tag),
      .dout_flags (dout_flags),
      .dout_valid (dout_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flags;
      logic [3:0]  tag;
      int          issue;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        rne;
      logic [31:0] res;
      logic [4:0]  fl;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[15];
   int   errors = 0;
   int   checks = 0;
   int   unexpected = 0;

   // Reference: {flags[4:0], result[31:0]} for single precision.
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic rne);
      logic        s, g, st;
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb, frac;
      logic [23:0] fr;
      logic [63:0] n, d, q, r;
      int          ca, cb, e;
      s  = a[31] ^ b[31];
      ea = a[30:23]; eb = b[30:23];
      fa = a[22:0];  fb = b[22:0];
      ca = (ea == 8'h00) ? 0 : (ea == 8'hFF) ? ((fa != 0) ? 3 : 2) : 1;
      cb = (eb == 8'h00) ? 0 : (eb == 8'hFF) ? ((fb != 0) ? 3 : 2) : 1;
      if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2))
         return {5'b10000, 32'h7FC00000};
      if (cb == 0)
         return {(ca == 1) ? 5'b01000 : 5'b00000, s, 8'hFF, 23'h0};
      if (ca == 2)
         return {5'b00000, s, 8'hFF, 23'h0};
      if (cb == 2 || ca == 0)
         return {5'b00000, s, 31'h0};
      n = {40'h0, 1'b1, fa} << 26;
      d = {40'h0, 1'b1, fb};
      q = n / d;
      r = n % d;
      e = int'(ea) - int'(eb) + 127;
      if (q[26]) begin
         frac = q[25:3]; g = q[2]; st = (q[1:0] != 0) || (r != 0);
      end else begin
         frac = q[24:2]; g = q[1]; st = q[0] || (r != 0); e = e - 1;
      end
      fr = {1'b0, frac} + ((rne && g && (st || frac[0])) ? 24'd1 : 24'd0);
      if (fr[23]) begin
         e    = e + 1;
         frac = 23'h0;
      end else begin
         frac = fr[22:0];
      end
      if (e >= 255)
         return rne ? {5'b00101, s, 8'hFF, 23'h0} : {5'b00101, s, 8'hFE, 23'h7FFFFF};
      if (e <= 0)
         return {5'b00011, s, 31'h0};
      return {4'b0000, g | st, s, e[7:0], frac};
   endfunction

   function automatic logic [31:0] rand_norm();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom())};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (dout_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            unexpected++;
            $display("FAIL unexpected_valid: got dout_valid=1 dout=%h expected no result", dout);
         end else begin
            e = sb.pop_front();
            check($sformatf("dout[tag%0d]", e.tag), dout, e.res);
            check($sformatf("flags[tag%0d]", e.tag), 32'(dout_flags), 32'(e.flags));
            check($sformatf("tag[tag%0d]", e.tag), 32'(dout_tag), 32'(e.tag));
            check($sformatf("latency[tag%0d]", e.tag), 32'(cyc - e.issue), 32'(LAT));
         end
      end
   endtask

   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic rne, input logic [3:0] tag,
                       input logic [31:0] er, input logic [4:0] ef);
      exp_t x;
      @(negedge clk);
      monitor();
      din_valid = v;
      din1      = a;
      din2      = b;
      rnd_rne   = rne;
      din_tag   = tag;
      if (v) begin
         x.res   = er;
         x.flags = ef;
         x.tag   = tag;
         x.issue = cyc;
         sb.push_back(x);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() > 0; i++)
         step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 5'h0);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results still pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      logic [36:0] r;
      logic [31:0] a, b;
      int          stray0;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 5'b00001};
      vecs[2]  = '{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 5'b00001};
      vecs[3]  = '{32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 5'b01000};
      vecs[4]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 5'b10000};
      vecs[5]  = '{32'hC0000000, 32'h7F800000, 1'b1, 32'h80000000, 5'b00000};
      vecs[6]  = '{32'h7F000000, 32'h3E800000, 1'b1, 32'h7F800000, 5'b00101};
      vecs[7]  = '{32'h7F000000, 32'h3E800000, 1'b0, 32'h7F7FFFFF, 5'b00101};
      vecs[8]  = '{32'h00800000, 32'h40000000, 1'b1, 32'h00000000, 5'b00011};
      vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000};
      vecs[10] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b10000};
      vecs[11] = '{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 5'b00000};
      vecs[12] = '{32'h00000000, 32'hC0A00000, 1'b1, 32'h80000000, 5'b00000};
      vecs[13] = '{32'h3F800000, 32'h80000000, 1'b0, 32'hFF800000, 5'b01000};
      vecs[14] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40400000, 5'b00000};

      nrst      = 1'b0;
      din_valid = 1'b0;
      din1      = '0;
      din2      = '0;
      rnd_rne   = 1'b0;
      din_tag   = '0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("reset_valid", 32'(dout_valid), 32'h0);
      check("reset_dout", dout, 32'h0);
      check("reset_tag", 32'(dout_tag), 32'h0);
      check("reset_flags", 32'(dout_flags), 32'h0);

      for (int i = 0; i < 15; i++)
         step(1'b1, vecs[i].a, vecs[i].b, vecs[i].rne, 4'(i), vecs[i].res, vecs[i].fl);
      drain();

      for (int i = 0; i < 1000; i++) begin
         a = rand_norm();
         b = rand_norm();
         r = model(a, b, i[0]);
         step(1'b1, a, b, i[0], i[3:0], r[31:0], r[36:32]);
      end
      drain();

      // Ten ops in flight; reset lands while the third result is on the output.
      for (int i = 0; i < 10; i++) begin
         a = rand_norm();
         b = rand_norm();
         r = model(a, b, 1'b1);
         step(1'b1, a, b, 1'b1, 4'(i), r[31:0], r[36:32]);
      end
      repeat (22) step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 5'h0);
      @(posedge clk);
      #2;
      check("pre_reset_valid", 32'(dout_valid), 32'h1);
      nrst = 1'b0;
      #1;
      check("async_reset_valid", 32'(dout_valid), 32'h0);
      check("async_reset_dout", dout, 32'h0);
      sb.delete();
      repeat (3) @(negedge clk);
      nrst   = 1'b1;
      stray0 = unexpected;
      repeat (40) step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 5'h0);
      check("stray_valid_after_reset", 32'(unexpected - stray0), 32'h0);
      step(1'b1, 32'h40C00000, 32'h40000000, 1'b1, 4'hA, 32'h40400000, 5'b00000);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
